mem_write_arbiter: RTL



---
 rtl/mem_write_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_write_arbiter.sv
// mem_write_arbiter: round-robin arbiter that funnels per-core write requests
// into a single registered output slot draining over a valid/ready handshake.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_EMPTY | output slot holds no write (mem_valid_o = 0)
// S_FULL  | output slot holds a write waiting for mem_ready_i
module mem_write_arbiter #(
    parameter int NUM_CORES      = 4,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int COUNT_WIDTH    = 16,
    localparam int IDX_W         = $clog2(NUM_CORES)
) (
    input  logic                                clk_i,
    input  logic                                reset_ni,
    input  logic [NUM_CORES-1:0]                req_valid_i,
    input  logic [NUM_CORES*MEM_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]     req_data_i,
    output logic [NUM_CORES-1:0]                req_ack_o,
    output logic                                mem_valid_o,
    output logic [MEM_ADDR_WIDTH-1:0]           mem_addr_o,
    output logic [DATA_WIDTH-1:0]               mem_data_o,
    input  logic                                mem_ready_i,
    output logic [IDX_W-1:0]                    grant_idx_o,
    output logic                                busy_o,
    output logic [COUNT_WIDTH-1:0]              write_count_o
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [NUM_CORES-1:0]   eligible;
    logic [NUM_CORES-1:0]   ack_d;
    logic [IDX_W-1:0]       winner;
    logic [IDX_W-1:0]       cand;
    logic                   found;
    logic                   slot_free;
    logic                   grant;

    assign mem_valid_o = (state_q == S_FULL);
    assign busy_o      = mem_valid_o || (|req_valid_i);

    // Round-robin search starting one past the last winner; a core whose ack
    // is visible this cycle is masked so a held valid is not granted twice.
    always_comb begin
        eligible = req_valid_i & ~req_ack_o;
        found    = 1'b0;
        winner   = grant_idx_o;
        cand     = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            cand = IDX_W'((int'(grant_idx_o) + i) % NUM_CORES);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Next-state and ack decode: the slot refills whenever it drains or is empty.
    always_comb begin
        state_d   = state_q;
        ack_d     = '0;
        slot_free = !mem_valid_o || mem_ready_i;
        grant     = slot_free && found;
        if (slot_free) begin
            state_d = grant ? S_FULL : S_EMPTY;
        end
        if (grant) begin
            ack_d[winner] = 1'b1;
        end
    end

    // State register and ack pulse.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= S_EMPTY;
            req_ack_o <= '0;
        end else begin
            state_q   <= state_d;
            req_ack_o <= ack_d;
        end
    end

    // Output slot payload and last-winner index; both hold unless a grant occurs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            grant_idx_o <= IDX_W'(NUM_CORES - 1);
        end else if (grant) begin
            mem_addr_o  <= req_addr_i[winner*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
            mem_data_o  <= req_data_i[winner*DATA_WIDTH +: DATA_WIDTH];
            grant_idx_o <= winner;
        end
    end

    // Completed-write counter, wrapping naturally.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            write_count_o <= '0;
        end else if (mem_valid_o && mem_ready_i) begin
            write_count_o <= write_count_o + COUNT_WIDTH'(1);
        end
    end

endmodule
